// File: rtl/mux_8_to_1_pkg.sv
// rtl/mux_8_to_1_pkg.sv - shared sizing constants for the 8-to-1 selector
//
// Purpose: select width and lane count used by the selector and its
// combinational core.
// Ports: none (package).

package mux_8_to_1_pkg;

  localparam int SEL_W     = 3;
  localparam int NUM_LANES = 8;

endpackage : mux_8_to_1_pkg

// File: rtl/mux_8_to_1_comb.sv
// rtl/mux_8_to_1_comb.sv - purely combinational 8-lane selector core
//
// Purpose: forwards lane dN to sel_val, where N is the unsigned value of opt.
// Ports:
//   d0..d7   in   WIDTH  data lanes, lane N picked when opt == N
//   opt      in   SEL_W  select, unsigned, MSB has weight 4
//   sel_val  out  WIDTH  selected lane

module mux_8_to_1_comb
  import mux_8_to_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [SEL_W-1:0] opt,
  output logic [WIDTH-1:0] sel_val
);

  // Lane N sits at array index N, so the pick is by numeric value of opt.
  // An X/Z select reads out as X in simulation, with no fallback lane.
  logic [WIDTH-1:0] lanes [NUM_LANES];

  assign lanes[0] = d0;
  assign lanes[1] = d1;
  assign lanes[2] = d2;
  assign lanes[3] = d3;
  assign lanes[4] = d4;
  assign lanes[5] = d5;
  assign lanes[6] = d6;
  assign lanes[7] = d7;

  assign sel_val = lanes[opt];

endmodule : mux_8_to_1_comb

// File: rtl/mux_8_to_1.sv
// rtl/mux_8_to_1.sv - 8-to-1 selector with optional registered output
//
// Purpose: picks one of eight data lanes by the unsigned value of opt.
// With OUT_REG=1 the result is registered (1-cycle latency, async clear);
// with OUT_REG=0 it is a straight combinational path.
// Ports:
//   clk     in   1      rising-edge clock (unused when OUT_REG=0)
//   rst_n   in   1      async active-low reset, clears o0 (unused when OUT_REG=0)
//   d0..d7  in   WIDTH  data lanes
//   opt     in   3      lane select
//   o0      out  WIDTH  selected data

module mux_8_to_1
  import mux_8_to_1_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [SEL_W-1:0] opt,
  output logic [WIDTH-1:0] o0
);

  logic [WIDTH-1:0] sel_val;

  mux_8_to_1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .d4      (d4),
    .d5      (d5),
    .d6      (d6),
    .d7      (d7),
    .opt     (opt),
    .sel_val (sel_val)
  );

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] o0_d;
    logic [WIDTH-1:0] o0_q;

    always_comb begin
      o0_d = sel_val;
    end

    // Reset is asynchronous so o0 clears the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o0_q <= '0;
      end else begin
        o0_q <= o0_d;
      end
    end

    assign o0 = o0_q;
  end else begin : g_bypass
    // clk and rst_n have no function on the combinational path.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};

    assign o0 = sel_val;
  end

endmodule : mux_8_to_1

// File: tb/tb_mux_8_to_1.sv
// tb/tb_mux_8_to_1.sv - self-checking bench for the 8-to-1 selector

module tb_mux_8_to_1;

  logic       clk;
  logic       rst_n;
  logic       d0, d1, d2, d3, d4, d5, d6, d7;
  logic [2:0] opt;
  logic       o0;

  logic [3:0] c_d0, c_d1, c_d2, c_d3, c_d4, c_d5, c_d6, c_d7;
  logic [2:0] c_opt;
  logic [3:0] c_o0;

  int checks;
  int errors;

  mux_8_to_1 #(
    .WIDTH   (1),
    .OUT_REG (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .d4    (d4),
    .d5    (d5),
    .d6    (d6),
    .d7    (d7),
    .opt   (opt),
    .o0    (o0)
  );

  mux_8_to_1 #(
    .WIDTH   (4),
    .OUT_REG (1'b0)
  ) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (c_d0),
    .d1    (c_d1),
    .d2    (c_d2),
    .d3    (c_d3),
    .d4    (c_d4),
    .d5    (c_d5),
    .d6    (c_d6),
    .d7    (c_d7),
    .opt   (c_opt),
    .o0    (c_o0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected bit is bit number opt of the packed lane byte.
  function automatic logic ref_bit(input int v, input int s);
    return logic'((v >> s) & 1);
  endfunction

  task automatic set_d(input logic [7:0] v);
    d0 = v[0]; d1 = v[1]; d2 = v[2]; d3 = v[3];
    d4 = v[4]; d5 = v[5]; d6 = v[6]; d7 = v[7];
  endtask

  task automatic set_c(input logic [3:0] lanes [8]);
    c_d0 = lanes[0]; c_d1 = lanes[1]; c_d2 = lanes[2]; c_d3 = lanes[3];
    c_d4 = lanes[4]; c_d5 = lanes[5]; c_d6 = lanes[6]; c_d7 = lanes[7];
  endtask

  task automatic test_reset_state();
    rst_n = 1'b0;
    set_d(8'hFF);
    opt = 3'd0;
    #1;
    checks++;
    if (o0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: o0=%b expected 0", o0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: o0=%b expected 0", o0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o0 !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: o0=%b expected 1", o0);
    end
  endtask

  task automatic test_sweep();
    int bad = 0;
    for (int v = 0; v < 256; v++) begin
      for (int s = 0; s < 8; s++) begin
        @(negedge clk);
        set_d(8'(v));
        opt = 3'(s);
        @(posedge clk);
        #1;
        checks++;
        if (o0 !== ref_bit(v, s)) begin
          errors++;
          if (bad < 10)
            $display("FAIL sweep d=%02h opt=%0d: o0=%b expected %b", v, s, o0, ref_bit(v, s));
          bad++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_d(8'hFF);
    opt = 3'd5;
    @(posedge clk);
    #1;
    checks++;
    if (o0 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: o0=%b expected 1", o0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: o0=%b expected 0 before clk edge", o0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_clk: o0=%b expected 0", o0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (o0 !== 1'b0) begin
      errors++;
      $display("FAIL release_no_edge: o0=%b expected 0", o0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o0 !== 1'b1) begin
      errors++;
      $display("FAIL release_capture: o0=%b expected 1", o0);
    end
  endtask

  task automatic test_one_hot();
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      set_d(8'b0000_1000);
      opt = 3'(s);
      @(posedge clk);
      #1;
      checks++;
      if (o0 !== ((s == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL one_hot opt=%0d: o0=%b expected %b", s, o0, (s == 3));
      end
    end
  endtask

  task automatic test_select_order();
    logic [0:2] rev;
    @(negedge clk);
    set_d(8'b1000_0000);
    opt = 3'b001;
    @(posedge clk);
    #1;
    checks++;
    if (o0 !== 1'b0) begin
      errors++;
      $display("FAIL order_opt1: o0=%b expected 0", o0);
    end
    @(negedge clk);
    opt = 3'b111;
    @(posedge clk);
    #1;
    checks++;
    if (o0 !== 1'b1) begin
      errors++;
      $display("FAIL order_opt7: o0=%b expected 1", o0);
    end
    // A select driven from an ascending-range vector still means its value.
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      set_d(8'(1 << j));
      rev = 3'(j);
      opt = rev;
      @(posedge clk);
      #1;
      checks++;
      if (o0 !== 1'b1) begin
        errors++;
        $display("FAIL order_rev j=%0d: o0=%b expected 1", j, o0);
      end
    end
  endtask

  task automatic test_comb_path();
    logic [3:0] lanes [8];
    for (int i = 0; i < 8; i++) lanes[i] = 4'($urandom_range(0, 15));
    lanes[2] = 4'hA;
    @(negedge clk);
    set_c(lanes);
    c_opt = 3'd2;
    #1;
    checks++;
    if (c_o0 !== 4'hA) begin
      errors++;
      $display("FAIL comb_d2: o0=%h expected a", c_o0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (c_o0 !== 4'hA) begin
      errors++;
      $display("FAIL comb_reset_low: o0=%h expected a", c_o0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (c_o0 !== 4'hA) begin
      errors++;
      $display("FAIL comb_reset_high: o0=%h expected a", c_o0);
    end
    for (int k = 0; k < 40; k++) begin
      int s;
      for (int i = 0; i < 8; i++) lanes[i] = 4'($urandom_range(0, 15));
      s = $urandom_range(0, 7);
      set_c(lanes);
      c_opt = 3'(s);
      #1;
      checks++;
      if (c_o0 !== lanes[s]) begin
        errors++;
        $display("FAIL comb_random opt=%0d: o0=%h expected %h", s, c_o0, lanes[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic prev;
    logic exp_q[$];
    // Register is live from the previous test; seed the model with a known value.
    @(negedge clk);
    set_d(8'h00);
    opt = 3'd0;
    @(posedge clk);
    prev = 1'b0;
    for (int k = 0; k < 200; k++) begin
      int v;
      int s;
      v = $urandom_range(0, 255);
      s = $urandom_range(0, 7);
      @(negedge clk);
      set_d(8'(v));
      opt = 3'(s);
      exp_q.push_back(ref_bit(v, s));
      #1;
      checks++;
      if (o0 !== prev) begin
        errors++;
        $display("FAIL b2b_hold k=%0d: o0=%b expected %b", k, o0, prev);
      end
      @(posedge clk);
      #1;
      prev = exp_q.pop_front();
      checks++;
      if (o0 !== prev) begin
        errors++;
        $display("FAIL b2b_capture k=%0d d=%02h opt=%0d: o0=%b expected %b", k, v, s, o0, prev);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_d(8'h00);
    opt    = 3'd0;
    c_d0 = '0; c_d1 = '0; c_d2 = '0; c_d3 = '0;
    c_d4 = '0; c_d5 = '0; c_d6 = '0; c_d7 = '0;
    c_opt  = 3'd0;

    test_reset_state();
    test_sweep();
    test_async_reset();
    test_one_hot();
    test_select_order();
    test_comb_path();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_8_to_1
